store_rmw_sequencer: RTL and testbench
======================================

// Module: store_rmw_sequencer
// PURPOSE
//   Multicycle store controller between the processor control unit and the 64-bit data memory.
//   Accepts one store request (sb/sh/sw/sd) and sequences the memory transaction.
//   Narrow stores use a read-modify-write of the enclosing doubleword, merging only the
//   addressed byte lanes. sd writes directly.
//   Reports completion or error back to the control unit with a one-cycle pulse.
// PARAMETERS
//   RD_LAT  1  cycles from mem_rd assertion to valid mem_rdata; legal 1..4
// PORTS
//   clk        in   1   system clock, rising edge
//   reset      in   1   asynchronous, active-high reset
//   st_start   in   1   store request; sampled only in IDLE
//   st_funct3  in   3   000 sb, 001 sh, 010 sw, 011 sd; all other codes are illegal
//   st_addr    in   64  byte address of the store
//   st_data    in   64  source register value; low bytes are used for narrow stores
//   st_busy    out  1   high in every state except IDLE
//   st_done    out  1   one-cycle completion pulse
//   st_err     out  1   one-cycle pulse coincident with st_done; request rejected, no write
//   mem_addr   out  64  doubleword address {st_addr[63:3],3'b000}, registered
//   mem_rd     out  1   one-cycle read strobe
//   mem_wr     out  1   one-cycle write strobe
//   mem_wdata  out  64  merged write data, registered
//   mem_rdata  in   64  memory read data
// BEHAVIOUR
//   - Reset: state=IDLE; all outputs 0; latched request and RD_LAT counter cleared.
//   - Reset mid-operation: abandons the operation immediately. No mem_wr is issued.
//     Any in-flight read data is discarded.
//   - States: IDLE, RD_REQ, RD_WAIT, WR, DONE.
//   - IDLE + st_start: latch funct3, addr and data, then branch:
//     - illegal funct3 -> DONE with err.
//     - sd -> WR.
//     - otherwise -> RD_REQ.
//   - RD_REQ: mem_rd=1 for exactly one cycle; load wait counter with RD_LAT; -> RD_WAIT.
//   - RD_WAIT: decrement counter each cycle. On the cycle the counter reaches 1:
//     - capture mem_rdata;
//     - form the merge;
//     - -> WR.
//     - Net effect: mem_rdata is sampled RD_LAT cycles after the mem_rd cycle.
//   - Merge (byte lane k = bits 8k+7:8k), with lane offset o = addr[2:0]:
//     - sb: lane o <- data[7:0].
//     - sh: lanes {o[2:1],0}..+1 <- data[15:0].
//     - sw: lanes {o[2],00}..+3 <- data[31:0].
//     - All other lanes keep the read value. No sign extension is applied.
//   - WR: mem_wr=1 for one cycle. mem_wdata is the merged value, or st_data for sd. -> DONE.
//   - DONE: st_done=1 for one cycle (st_err as decided at accept); -> IDLE.
//   - st_start outside IDLE is ignored; it is neither queued nor an error.
//   - mem_rd and mem_wr are never high in the same cycle.
//   - mem_addr/mem_wdata are updated only on entry to RD_REQ or WR, and hold otherwise.
//   - Latency, with the accept cycle as cycle 0:
//     - sd: WR at cycle 1, done at cycle 2.
//     - narrow: RD_REQ at 1, WR at RD_LAT+2, done at RD_LAT+3.
//     - illegal: done+err at cycle 1.
// CONFIGURATION
//   MISALIGN_TRAP_EN defined:
//     - Misalignment is checked at accept: sh with addr[0]!=0; sw with addr[1:0]!=0;
//       sd with addr[2:0]!=0.
//     - A misaligned request goes to DONE with st_err=1 and no memory access.
//   MISALIGN_TRAP_EN undefined:
//     - Low address bits below the access size are ignored, e.g. sh @0x101 writes lanes 0-1.
//     - sd always writes the aligned doubleword.
//     - st_err is raised only for illegal funct3.
// TESTING
//   1. RD_LAT=1; sd addr 0x100, data 0x1122334455667788
//      -> mem_wr at cycle 1, mem_addr 0x100, wdata 0x1122334455667788;
//         mem_rd never asserted; done at cycle 2.
//   2. sb addr 0x103, data 0xFFFFFFFFFFFFFFAB, mem_rdata 0x0
//      -> mem_rd at cycle 1 with mem_addr 0x100; wdata 0x00000000AB000000; done at cycle 4.
//   3. sw addr 0x204, data 0xDEADBEEF, mem_rdata 0x1111111122222222
//      -> wdata 0xDEADBEEF22222222.
//   4. funct3=3'b100 -> st_done=st_err=1 at cycle 1; no mem_rd/mem_wr; st_start held high
//      during DONE is ignored.
//   5. RD_LAT=3; reset asserted during RD_WAIT -> all outputs 0, no mem_wr.
//      A following sb then completes with done at cycle 6.
//   6. sh addr 0x101, data 0xBEEF, rdata 0x0:
//      - with MISALIGN_TRAP_EN -> err, no access;
//      - without -> wdata 0x000000000000BEEF.

Source files
------------

// File: rtl/store_rmw_sequencer.sv
// Multicycle store sequencer: read-modify-write for sb/sh/sw, direct write for sd.
// Define MISALIGN_TRAP_EN to reject misaligned sh/sw/sd with st_err.
`timescale 1ns/1ps

module store_rmw_sequencer #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_start,
  input  logic [2:0]  st_funct3,
  input  logic [63:0] st_addr,
  input  logic [63:0] st_data,
  output logic        st_busy,
  output logic        st_done,
  output logic        st_err,
  output logic [63:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR,
    DONE
  } state_t;

  localparam logic [2:0] LAT = 3'(RD_LAT);

  state_t      state;
  logic [1:0]  size_q;
  logic [2:0]  off_q;
  logic [31:0] data_q;
  logic [2:0]  cnt;

  logic        mis;
  logic        reject;
  logic [63:0] aligned;
  logic [7:0]  be;
  logic [63:0] rep;
  logic [63:0] merged;

  assign aligned = {st_addr[63:3], 3'b000};

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    mis = 1'b0;
    unique case (st_funct3)
      3'b001:  mis = st_addr[0];
      3'b010:  mis = |st_addr[1:0];
      3'b011:  mis = |st_addr[2:0];
      default: mis = 1'b0;
    endcase
  end
`else
  assign mis = 1'b0;
`endif

  assign reject = st_funct3[2] | mis;

  // Narrow source data is replicated so every lane offers the right byte.
  always_comb begin
    be  = '0;
    rep = '0;
    unique case (size_q)
      2'b00: begin
        be[off_q] = 1'b1;
        rep = {8{data_q[7:0]}};
      end
      2'b01: begin
        be[{off_q[2:1], 1'b0} +: 2] = 2'b11;
        rep = {4{data_q[15:0]}};
      end
      2'b10: begin
        be[{off_q[2], 2'b00} +: 4] = 4'hf;
        rep = {2{data_q[31:0]}};
      end
      default: begin
        be  = 8'hff;
        rep = {2{data_q[31:0]}};
      end
    endcase
  end

  always_comb begin
    merged = mem_rdata;
    for (int k = 0; k < 8; k++) begin
      if (be[k]) merged[8*k +: 8] = rep[8*k +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      size_q    <= '0;
      off_q     <= '0;
      data_q    <= '0;
      cnt       <= '0;
      st_busy   <= 1'b0;
      st_done   <= 1'b0;
      st_err    <= 1'b0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
      st_done <= 1'b0;
      st_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (st_start) begin
            size_q  <= st_funct3[1:0];
            off_q   <= st_addr[2:0];
            data_q  <= st_data[31:0];
            st_busy <= 1'b1;
            if (reject) begin
              state   <= DONE;
              st_done <= 1'b1;
              st_err  <= 1'b1;
            end else if (st_funct3[1:0] == 2'b11) begin
              state     <= WR;
              mem_wr    <= 1'b1;
              mem_addr  <= aligned;
              mem_wdata <= st_data;
            end else begin
              state    <= RD_REQ;
              mem_rd   <= 1'b1;
              mem_addr <= aligned;
            end
          end
        end
        RD_REQ: begin
          cnt   <= LAT;
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          cnt <= 3'(cnt - 3'd1);
          if (cnt == 3'd1) begin
            mem_wdata <= merged;
            mem_wr    <= 1'b1;
            state     <= WR;
          end
        end
        WR: begin
          st_done <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          st_busy <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          st_busy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_rmw_sequencer.sv
// Bench for store_rmw_sequencer: RD_LAT=1 and RD_LAT=3 instances,
// latency-exact memory responder and a byte-lane reference model.
`timescale 1ns/1ps

module tb_store_rmw_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic        start1 = 1'b0;
  logic        start3 = 1'b0;
  logic [2:0]  f3 = '0;
  logic [63:0] addr = '0;
  logic [63:0] data = '0;
  logic [63:0] rdata = '0;

  logic        busy1, done1, err1, rd1, wr1;
  logic [63:0] maddr1, wdata1;
  logic        busy3, done3, err3, rd3, wr3;
  logic [63:0] maddr3, wdata3;

  logic        busy, done, err, rd, wr;
  logic [63:0] maddr, wdata;

  assign busy  = sel ? busy3 : busy1;
  assign done  = sel ? done3 : done1;
  assign err   = sel ? err3 : err1;
  assign rd    = sel ? rd3 : rd1;
  assign wr    = sel ? wr3 : wr1;
  assign maddr = sel ? maddr3 : maddr1;
  assign wdata = sel ? wdata3 : wdata1;

  store_rmw_sequencer #(.RD_LAT(1)) u1 (
    .clk(clk), .reset(rst), .st_start(start1),
    .st_funct3(f3), .st_addr(addr), .st_data(data),
    .st_busy(busy1), .st_done(done1), .st_err(err1),
    .mem_addr(maddr1), .mem_rd(rd1), .mem_wr(wr1),
    .mem_wdata(wdata1), .mem_rdata(rdata)
  );

  store_rmw_sequencer #(.RD_LAT(3)) u3 (
    .clk(clk), .reset(rst), .st_start(start3),
    .st_funct3(f3), .st_addr(addr), .st_data(data),
    .st_busy(busy3), .st_done(done3), .st_err(err3),
    .mem_addr(maddr3), .mem_rd(rd3), .mem_wr(wr3),
    .mem_wdata(wdata3), .mem_rdata(rdata)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [63:0] refmem [logic [63:0]];

  function automatic logic [63:0] mem_val(logic [63:0] a);
    if (refmem.exists(a)) return refmem[a];
    return {~a[31:0], a[31:0] ^ 32'h5a5a_c3c3};
  endfunction

  // Valid read data only in the one cycle the sequencer must sample it.
  int          rcnt = 0;
  logic [63:0] raddr = '0;
  always @(negedge clk) begin
    logic hit;
    hit = 1'b0;
    if (rst) rcnt = 0;
    else if (rcnt > 0) begin
      rcnt--;
      hit = (rcnt == 0);
    end
    rdata = hit ? mem_val(raddr) : {$urandom(), $urandom()};
    if (!rst && rd) begin
      rcnt  = sel ? 3 : 1;
      raddr = maddr;
    end
  end

  function automatic logic [63:0] model_merge(logic [63:0] old, logic [2:0] f,
                                              logic [63:0] a, logic [63:0] d);
    int size = 1 << f[1:0];
    int first = int'(a[2:0]) & ~(size - 1);
    logic [63:0] r = old;
    for (int i = 0; i < size; i++) r[(first + i) * 8 +: 8] = d[i * 8 +: 8];
    return r;
  endfunction

  function automatic bit model_err(logic [2:0] f, logic [63:0] a);
    int size = 1 << f[1:0];
    if (f[2]) return 1'b1;
`ifdef MISALIGN_TRAP_EN
    if ((int'(a[2:0]) % size) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic int model_done(bit s, logic [2:0] f, logic [63:0] a);
    if (model_err(f, a)) return 1;
    if (f[1:0] == 2'b11) return 2;
    return (s ? 3 : 1) + 3;
  endfunction

  int          o_rd_n, o_rd_cyc, o_wr_n, o_wr_cyc;
  int          o_done_n, o_done_cyc, o_err_n, o_err_cyc;
  int          o_both, o_busy_end;
  logic        o_busy0;
  bit          o_timeout;
  logic [63:0] o_rd_addr, o_wr_addr, o_wr_data;

  task automatic drive(input bit s, input logic [2:0] f, input logic [63:0] a,
                       input logic [63:0] d, input int hold);
    sel = s;
    @(negedge clk);
    f3 = f;
    addr = a;
    data = d;
    if (s) start3 = 1'b1;
    else start1 = 1'b1;
    o_busy0 = busy;
    o_rd_n = 0; o_rd_cyc = 0; o_wr_n = 0; o_wr_cyc = 0;
    o_done_n = 0; o_done_cyc = 0; o_err_n = 0; o_err_cyc = 0;
    o_both = 0; o_busy_end = 0;
    o_rd_addr = '0; o_wr_addr = '0; o_wr_data = '0;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (rd) begin o_rd_n++; o_rd_cyc = c; o_rd_addr = maddr; end
      if (wr) begin o_wr_n++; o_wr_cyc = c; o_wr_addr = maddr; o_wr_data = wdata; end
      if (rd && wr) o_both++;
      if (done) begin o_done_n++; o_done_cyc = c; end
      if (err) begin o_err_n++; o_err_cyc = c; end
      if (!busy && o_busy_end == 0) o_busy_end = c;
      if (c >= hold) begin start1 = 1'b0; start3 = 1'b0; end
      if (o_done_n > 0 && c >= o_done_cyc + 3) break;
    end
    start1 = 1'b0;
    start3 = 1'b0;
    o_timeout = (o_done_n == 0);
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    total++;
    if ({busy1, done1, err1, rd1, wr1, maddr1, wdata1} !== '0)
      $display("FAIL reset_u1 got=%0h want=0", {busy1, done1, err1, rd1, wr1, maddr1, wdata1});
    else passed++;
    total++;
    if ({busy3, done3, err3, rd3, wr3, maddr3, wdata3} !== '0)
      $display("FAIL reset_u3 got=%0h want=0", {busy3, done3, err3, rd3, wr3, maddr3, wdata3});
    else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sd();
    drive(1'b0, 3'b011, 64'h100, 64'h1122334455667788, 1);
    total++;
    if (o_wr_cyc !== 1 || o_wr_n !== 1) $display("FAIL sd_wr got cyc=%0d n=%0d want cyc=1 n=1", o_wr_cyc, o_wr_n);
    else passed++;
    total++;
    if (o_wr_addr !== 64'h100) $display("FAIL sd_addr got=%0h want=100", o_wr_addr);
    else passed++;
    total++;
    if (o_wr_data !== 64'h1122334455667788) $display("FAIL sd_wdata got=%0h want=1122334455667788", o_wr_data);
    else passed++;
    total++;
    if (o_rd_n !== 0) $display("FAIL sd_no_rd got=%0d want=0", o_rd_n);
    else passed++;
    total++;
    if (o_done_cyc !== 2 || o_err_n !== 0) $display("FAIL sd_done got cyc=%0d err=%0d want cyc=2 err=0", o_done_cyc, o_err_n);
    else passed++;
    total++;
    if (o_busy0 !== 1'b0 || o_busy_end !== 3) $display("FAIL sd_busy got b0=%0b end=%0d want b0=0 end=3", o_busy0, o_busy_end);
    else passed++;
    refmem[64'h100] = 64'h1122334455667788;
  endtask

  task automatic test_sb();
    refmem[64'h100] = 64'h0;
    drive(1'b0, 3'b000, 64'h103, 64'hffffffffffffffab, 1);
    total++;
    if (o_rd_cyc !== 1 || o_rd_n !== 1 || o_rd_addr !== 64'h100)
      $display("FAIL sb_rd got cyc=%0d n=%0d addr=%0h want cyc=1 n=1 addr=100", o_rd_cyc, o_rd_n, o_rd_addr);
    else passed++;
    total++;
    if (o_wr_data !== 64'h00000000ab000000) $display("FAIL sb_wdata got=%0h want=ab000000", o_wr_data);
    else passed++;
    total++;
    if (o_wr_cyc !== 3 || o_done_cyc !== 4) $display("FAIL sb_lat got wr=%0d done=%0d want wr=3 done=4", o_wr_cyc, o_done_cyc);
    else passed++;
    refmem[64'h100] = 64'h00000000ab000000;
  endtask

  task automatic test_sw();
    refmem[64'h200] = 64'h1111111122222222;
    drive(1'b0, 3'b010, 64'h204, 64'hdeadbeef, 1);
    total++;
    if (o_wr_data !== 64'hdeadbeef22222222) $display("FAIL sw_wdata got=%0h want=deadbeef22222222", o_wr_data);
    else passed++;
    total++;
    if (o_wr_addr !== 64'h200 || o_done_cyc !== 4) $display("FAIL sw_addr_done got addr=%0h done=%0d want addr=200 done=4", o_wr_addr, o_done_cyc);
    else passed++;
    refmem[64'h200] = 64'hdeadbeef22222222;
  endtask

  task automatic test_illegal();
    drive(1'b0, 3'b100, 64'h300, 64'h55, 2);
    total++;
    if (o_done_cyc !== 1 || o_err_cyc !== 1 || o_done_n !== 1 || o_err_n !== 1)
      $display("FAIL ill_done got done=%0d/%0d err=%0d/%0d want 1/1 1/1", o_done_cyc, o_done_n, o_err_cyc, o_err_n);
    else passed++;
    total++;
    if (o_rd_n + o_wr_n !== 0) $display("FAIL ill_noacc got=%0d want=0", o_rd_n + o_wr_n);
    else passed++;
    total++;
    if (o_busy_end !== 2) $display("FAIL ill_held_start got busy_end=%0d want=2", o_busy_end);
    else passed++;
  endtask

  task automatic test_reset_abort();
    int wr_seen;
    sel = 1'b1;
    wr_seen = 0;
    @(negedge clk);
    f3 = 3'b000;
    addr = 64'h408;
    data = 64'h77;
    start3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start3 = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (busy3 !== 1'b1) $display("FAIL abort_busy got=%0b want=1", busy3);
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if ({busy3, done3, err3, rd3, wr3, maddr3, wdata3} !== '0)
      $display("FAIL abort_outs got=%0h want=0", {busy3, done3, err3, rd3, wr3, maddr3, wdata3});
    else passed++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (wr3 || busy3) wr_seen++;
      if (i == 1) rst = 1'b0;
    end
    total++;
    if (wr_seen !== 0) $display("FAIL abort_nowr got=%0d want=0", wr_seen);
    else passed++;
    refmem[64'h408] = 64'h0123456789abcdef;
    drive(1'b1, 3'b000, 64'h40d, 64'h5a, 1);
    total++;
    if (o_done_cyc !== 6 || o_wr_data !== 64'h01235a6789abcdef)
      $display("FAIL abort_next got done=%0d wd=%0h want done=6 wd=1235a6789abcdef", o_done_cyc, o_wr_data);
    else passed++;
    refmem[64'h408] = 64'h01235a6789abcdef;
  endtask

  task automatic test_misalign();
    refmem[64'h100] = 64'h0;
    drive(1'b0, 3'b001, 64'h101, 64'hbeef, 1);
`ifdef MISALIGN_TRAP_EN
    total++;
    if (o_err_cyc !== 1 || o_done_cyc !== 1 || o_rd_n + o_wr_n !== 0)
      $display("FAIL mis_trap got err=%0d done=%0d acc=%0d want 1 1 0", o_err_cyc, o_done_cyc, o_rd_n + o_wr_n);
    else passed++;
`else
    total++;
    if (o_wr_data !== 64'hbeef || o_err_n !== 0 || o_done_cyc !== 4)
      $display("FAIL mis_ignore got wd=%0h err=%0d done=%0d want beef 0 4", o_wr_data, o_err_n, o_done_cyc);
    else passed++;
    refmem[64'h100] = 64'hbeef;
`endif
  endtask

  task automatic test_held_start();
    refmem[64'h500] = 64'hffffffffffffffff;
    drive(1'b1, 3'b001, 64'h506, 64'h1234, 6);
    total++;
    if (o_rd_n !== 1 || o_wr_n !== 1 || o_done_n !== 1)
      $display("FAIL held_once got rd=%0d wr=%0d done=%0d want 1 1 1", o_rd_n, o_wr_n, o_done_n);
    else passed++;
    total++;
    if (o_wr_data !== 64'h1234ffffffffffff) $display("FAIL held_wdata got=%0h want=1234ffffffffffff", o_wr_data);
    else passed++;
    refmem[64'h500] = 64'h1234ffffffffffff;
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      bit          s;
      logic [2:0]  f;
      logic [63:0] a, d, al, exp_wd;
      bit          e;
      int          lat;
      s = 1'($urandom_range(0, 1));
      f = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      a = 64'h1000 + 64'($urandom_range(0, 3) << 3) + 64'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) a[63:32] = $urandom();
      d = {$urandom(), $urandom()};
      al = {a[63:3], 3'b000};
      e = model_err(f, a);
      lat = model_done(s, f, a);
      exp_wd = (f[1:0] == 2'b11) ? d : model_merge(mem_val(al), f, a, d);
      drive(s, f, a, d, 1);
      total++;
      if (o_timeout) $display("FAIL rnd%0d_timeout got no done want done", n);
      else passed++;
      total++;
      if (o_done_cyc !== lat || o_done_n !== 1 || o_busy_end !== lat + 1)
        $display("FAIL rnd%0d_lat got done=%0d n=%0d bend=%0d want done=%0d", n, o_done_cyc, o_done_n, o_busy_end, lat);
      else passed++;
      total++;
      if (o_err_n !== int'(e) || (e && o_err_cyc !== 1))
        $display("FAIL rnd%0d_err got=%0d want=%0d", n, o_err_n, e);
      else passed++;
      total++;
      if (o_both !== 0) $display("FAIL rnd%0d_rdwr_overlap got=%0d want=0", n, o_both);
      else passed++;
      if (e) begin
        total++;
        if (o_rd_n + o_wr_n !== 0) $display("FAIL rnd%0d_noacc got=%0d want=0", n, o_rd_n + o_wr_n);
        else passed++;
      end else begin
        total++;
        if (o_wr_n !== 1 || o_wr_addr !== al || o_wr_data !== exp_wd)
          $display("FAIL rnd%0d_wr got n=%0d a=%0h d=%0h want n=1 a=%0h d=%0h", n, o_wr_n, o_wr_addr, o_wr_data, al, exp_wd);
        else passed++;
        total++;
        if (o_rd_n !== ((f[1:0] == 2'b11) ? 0 : 1))
          $display("FAIL rnd%0d_rd got=%0d want=%0d", n, o_rd_n, (f[1:0] == 2'b11) ? 0 : 1);
        else passed++;
        refmem[al] = exp_wd;
      end
    end
  endtask

  initial begin
    test_reset();
    test_sd();
    test_sb();
    test_sw();
    test_illegal();
    test_reset_abort();
    test_misalign();
    test_held_start();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
